// File: rtl/la_clk_pkg.sv
// Shared definitions for the logic-analyser clock domain: reset-sequencer FSM
// states and the lock/stagger timing defaults also used by the PLL wrapper.
package la_clk_pkg;

  typedef enum logic [1:0] {
    S_WAIT,
    S_QUAL,
    S_REL,
    S_RUN
  } la_rst_state_t;

  localparam int LA_LOCK_STABLE_CYC = 1024;
  localparam int LA_STAGE_GAP_CYC   = 16;

  // Width of a counter that runs 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/la_sync.sv
// Single-bit N-flop synchronizer with synchronous active-high reset to 0.
module la_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // NOTE: sequential state uses non-blocking assignments so every flop in the
  // chain samples its predecessor's pre-edge value, giving a true shift.
  always_ff @(posedge clk) begin
    if (rst) ff <= '0;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/la_rst_seq.sv
// Lock-qualified reset sequencer: qualifies PLL lock, releases staggered
// domain resets, and counts lock losses that occur after the first release.
module la_rst_seq
  import la_clk_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int LOCK_STABLE_CYC = LA_LOCK_STABLE_CYC,
  parameter int STAGE_GAP_CYC   = LA_STAGE_GAP_CYC,
  parameter int N_STAGES        = 3,
  parameter int CNT_W           = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pll_lock,
  input  logic                soft_rst_req,
  input  logic                clr_status,
  output logic [N_STAGES-1:0] rst_out,
  output logic                ready,
  output logic [CNT_W-1:0]    lock_loss_cnt,
  output logic                lock_lost_sticky
);

  localparam int QW = cnt_w(LOCK_STABLE_CYC);
  localparam int GW = cnt_w(STAGE_GAP_CYC);
  localparam int SW = $clog2(N_STAGES + 1);

  localparam logic [QW-1:0] Q_LAST = QW'(LOCK_STABLE_CYC - 1);
  localparam logic [GW-1:0] G_LAST = GW'(STAGE_GAP_CYC - 1);
  localparam logic [SW-1:0] S_ALL  = SW'(N_STAGES);

  logic                lk_s;
  la_rst_state_t       state, state_nxt;
  logic [QW-1:0]       qcnt, qcnt_nxt;
  logic [GW-1:0]       gcnt, gcnt_nxt;
  logic [SW-1:0]       stg, stg_nxt;
  logic [N_STAGES-1:0] rst_out_nxt;
  logic                ready_nxt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                sticky_nxt;
  logic                loss;

  la_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock),
    .q   (lk_s)
  );

  // NOTE: every signal assigned here gets a hold-value default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    qcnt_nxt    = qcnt;
    gcnt_nxt    = gcnt;
    stg_nxt     = stg;
    rst_out_nxt = rst_out;
    ready_nxt   = ready;
    cnt_nxt     = lock_loss_cnt;
    sticky_nxt  = lock_lost_sticky;
    loss        = 1'b0;

    case (state)
      S_WAIT: begin
        rst_out_nxt = '1;
        ready_nxt   = 1'b0;
        qcnt_nxt    = '0;
        if (lk_s) state_nxt = S_QUAL;
      end

      S_QUAL: begin
        if (!lk_s) begin
          state_nxt = S_WAIT;
          qcnt_nxt  = '0;
        end else if (qcnt == Q_LAST) begin
          state_nxt      = S_REL;
          qcnt_nxt       = '0;
          gcnt_nxt       = '0;
          stg_nxt        = SW'(1);
          rst_out_nxt[0] = 1'b0;
        end else begin
          qcnt_nxt = qcnt + 1'b1;
        end
      end

      S_REL, S_RUN: begin
        // Lock loss outranks a soft request arriving on the same cycle.
        if (!lk_s) begin
          loss        = 1'b1;
          state_nxt   = S_WAIT;
          rst_out_nxt = '1;
          ready_nxt   = 1'b0;
        end else if (soft_rst_req) begin
          state_nxt   = S_REL;
          gcnt_nxt    = '0;
          stg_nxt     = '0;
          rst_out_nxt = '1;
          ready_nxt   = 1'b0;
        end else if (state == S_REL) begin
          if (gcnt == G_LAST) begin
            gcnt_nxt = '0;
            if (stg == S_ALL) begin
              state_nxt = S_RUN;
              ready_nxt = 1'b1;
            end else begin
              for (int k = 0; k < N_STAGES; k++) begin
                if (SW'(k) == stg) rst_out_nxt[k] = 1'b0;
              end
              stg_nxt = stg + 1'b1;
            end
          end else begin
            gcnt_nxt = gcnt + 1'b1;
          end
        end
      end

      default: state_nxt = S_WAIT;
    endcase

    if (clr_status) begin
      cnt_nxt    = '0;
      sticky_nxt = 1'b0;
    end else if (loss) begin
      if (lock_loss_cnt != '1) cnt_nxt = lock_loss_cnt + 1'b1;
      sticky_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_WAIT;
      qcnt             <= '0;
      gcnt             <= '0;
      stg              <= '0;
      rst_out          <= '1;
      ready            <= 1'b0;
      lock_loss_cnt    <= '0;
      lock_lost_sticky <= 1'b0;
    end else begin
      state            <= state_nxt;
      qcnt             <= qcnt_nxt;
      gcnt             <= gcnt_nxt;
      stg              <= stg_nxt;
      rst_out          <= rst_out_nxt;
      ready            <= ready_nxt;
      lock_loss_cnt    <= cnt_nxt;
      lock_lost_sticky <= sticky_nxt;
    end
  end

endmodule

// File: doc/la_rst_seq.md
# la_rst_seq

Lock-qualified reset sequencer for the logic-analyser clock domain. It sits directly downstream of the logic-analyser PLL wrapper and is clocked by that PLL's `clkout0` (~180 MHz). It consumes the asynchronous `pll_lock` flag and qualifies it for a programmable stable interval. It then releases a staggered set of active-high domain resets, and records every loss of lock.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flops in the `pll_lock` synchronizer; legal range 2..4.
- `LOCK_STABLE_CYC`, default 1024: consecutive synced-lock cycles required before any release; ≥2.
- `STAGE_GAP_CYC`, default 16: cycles between successive stage releases; ≥1.
- `N_STAGES`, default 3: number of reset outputs; 1..8.
- `CNT_W`, default 16: width of the lock-loss counter.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  PLL `clkout0`.
- `rst`  in  1  synchronous, active-high block reset.
- `pll_lock`  in  1  asynchronous PLL lock flag.
- `soft_rst_req`  in  1  single-cycle request to re-run the release sequence.
- `clr_status`  in  1  clears `lock_loss_cnt` and `lock_lost_sticky`.
- `rst_out`  out  N_STAGES  active-high domain resets; bit 0 is released first.
- `ready`  out  1  high once all stages are released and the gap has elapsed.
- `lock_loss_cnt`  out  CNT_W  saturating count of lock losses after first release.
- `lock_lost_sticky`  out  1  set on any counted lock loss.

## Operation
- `pll_lock` passes through a `SYNC_STAGES`-flop synchronizer to give `lk_s`. No other logic samples `pll_lock`.
- FSM states and transitions:
  - S_WAIT: all `rst_out`=1. Goes to S_QUAL when `lk_s`=1.
  - S_QUAL: the qualification counter `qcnt` counts from 0. If `lk_s`=0, go to S_WAIT with `qcnt` cleared. When `qcnt`==LOCK_STABLE_CYC-1 and `lk_s`=1, go to S_REL and deassert `rst_out[0]`.
  - S_REL: the gap counter runs. Each time it reaches STAGE_GAP_CYC-1, the next `rst_out` bit deasserts. Once the last bit is released, one further full gap leads to S_RUN.
  - S_RUN: `ready`=1.
- Lock drop (`lk_s`=0) in S_REL or S_RUN:
  - all `rst_out` go to 1 on the next edge, `ready` goes to 0, and the FSM goes to S_WAIT;
  - `lock_loss_cnt` increments, saturating at all-ones;
  - `lock_lost_sticky` is set.
- A lock drop in S_QUAL is not counted, because no stage has been released yet.
- `soft_rst_req` in S_REL or S_RUN: all `rst_out`=1 and `ready`=0 on the next edge. The FSM enters S_REL with its counters cleared, so release restarts one gap later at stage 0. The counter is unchanged. The request is ignored in S_WAIT and S_QUAL.
- Simultaneous events:
  - Lock drop together with `soft_rst_req`: the lock-drop path wins.
  - `clr_status` together with a counted loss: the clear wins, leaving cnt=0 and sticky=0.
- `rst` values: state S_WAIT, synchronizer flops 0, `rst_out` all 1, `ready` 0, `lock_loss_cnt` 0, `lock_lost_sticky` 0. `rst` has priority over every other input, including mid-sequence.
- All outputs are driven directly from flops; there are no combinational paths from inputs to outputs.

## Timing
- `lk_s` follows a `pll_lock` change SYNC_STAGES cycles after it is sampled.
- Release schedule, taking `lk_s` rising at cycle t:
  - S_QUAL is entered at t+1;
  - `rst_out[0]` falls at t+LOCK_STABLE_CYC+1;
  - `rst_out[k]` falls k·STAGE_GAP_CYC cycles after `rst_out[0]`;
  - `ready` rises N_STAGES·STAGE_GAP_CYC cycles after `rst_out[0]`.
- Lock drop to all-asserted: `lk_s` low at cycle u gives `rst_out` all 1 at u+1. Worst case from `pll_lock` to all-asserted is SYNC_STAGES+1 cycles.
- `soft_rst_req` at cycle v:
  - all `rst_out` asserted at v+1;
  - `rst_out[0]` falls at v+1+STAGE_GAP_CYC.
- Counter and sticky bit update on the same edge that asserts `rst_out`.

## Structure
- Shared package `la_clk_pkg` holds:
  - the FSM state enum (S_WAIT, S_QUAL, S_REL, S_RUN);
  - the default values of LOCK_STABLE_CYC and STAGE_GAP_CYC, so the PLL wrapper and this block share one source.
- One sub-module, `la_sync`: a parameterised N-flop single-bit synchronizer with a synchronous active-high reset to 0. It is reused elsewhere in the logic-analyser domain.
- Counter widths are $clog2 of the respective parameter. `qcnt` and the gap counter are never wider than needed.

## Test plan
All scenarios use SYNC_STAGES=2, LOCK_STABLE_CYC=8, STAGE_GAP_CYC=4, N_STAGES=3, CNT_W=16, with cycles counted from the sampling edge.
- Clean lock, `pll_lock` sampled high at cycle 10 -> `lk_s` high at 12, `rst_out[0]` falls at 21, `rst_out[1]` at 25, `rst_out[2]` at 29, `ready` rises at 33, cnt stays 0.
- Lock glitch: high 5 cycles, low 1, then high -> qualification restarts. No release until 8 consecutive `lk_s` cycles, and cnt stays 0.
- Lock drop in S_RUN -> all `rst_out` are 1 within 3 cycles of `pll_lock` falling, `ready`=0, cnt=1, sticky=1. Relock repeats the full schedule.
- Saturation with CNT_W=2: five losses after release -> cnt=3, and `clr_status` returns it to 0 and sticky to 0.
- `soft_rst_req` in S_RUN -> all asserted next cycle, `rst_out[0]` falls 4 cycles later, cnt unchanged. The same request together with a lock drop -> S_WAIT entered and cnt incremented by 1.
- `rst` pulsed mid-S_REL, with `rst_out`=3'b100 -> all outputs at their `rst` values on the next edge. Sequencing restarts from S_WAIT.
